// File: rtl/rom_reader.sv
// ============================================================================
// Module   : rom_reader
// Purpose  : Streams an inclusive, wrapping address range of a combinational
//            ROM out as a valid/ready byte stream with last flag and done pulse.
//            Optional trailing mod-256 checksum byte: ROM_READER_CKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_reader #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DWELL  = 0
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [7:0]        C_DWELL_CNT = 8'(DWELL);
    localparam logic [ADDR_W-1:0] C_ADDR_ONE  = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_PRESENT = 3'd2,
`ifdef ROM_READER_CKSUM_EN
        S_CKSUM   = 3'd3,
`endif
        S_DONE    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [7:0]        dwell_cnt_q, dwell_cnt_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              w_accept;
    logic              w_at_last;

`ifdef ROM_READER_CKSUM_EN
    logic [7:0]        cksum_q, cksum_d;
    logic [7:0]        w_cksum_next;
`endif

    assign w_accept  = out_valid_q && out_ready;
    assign w_at_last = (rom_addr_q == last_q);

`ifdef ROM_READER_CKSUM_EN
    // Running sum including the byte being accepted this cycle.
    assign w_cksum_next = cksum_q + 8'(out_data_q);
`endif

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rom_addr_q  <= '0;
            last_q      <= '0;
            dwell_cnt_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
`ifdef ROM_READER_CKSUM_EN
            cksum_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            last_q      <= last_d;
            dwell_cnt_q <= dwell_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
`ifdef ROM_READER_CKSUM_EN
            cksum_q     <= cksum_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        last_d      = last_q;
        dwell_cnt_d = dwell_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
`ifdef ROM_READER_CKSUM_EN
        cksum_d     = cksum_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    last_d      = last_addr;
                    rom_addr_d  = first_addr;
                    dwell_cnt_d = '0;
`ifdef ROM_READER_CKSUM_EN
                    cksum_d     = '0;
`endif
                    state_d     = S_SETTLE;
                end
            end

            S_SETTLE: begin
                if (dwell_cnt_q == C_DWELL_CNT) begin
                    out_data_d  = rom_data;
                    out_valid_d = 1'b1;
`ifdef ROM_READER_CKSUM_EN
                    // The checksum byte carries the last flag instead.
                    out_last_d  = 1'b0;
`else
                    out_last_d  = w_at_last;
`endif
                    state_d     = S_PRESENT;
                end else begin
                    dwell_cnt_d = dwell_cnt_q + 8'd1;
                end
            end

            S_PRESENT: begin
                if (w_accept) begin
                    out_valid_d = 1'b0;
`ifdef ROM_READER_CKSUM_EN
                    cksum_d     = w_cksum_next;
`endif
                    if (w_at_last) begin
`ifdef ROM_READER_CKSUM_EN
                        out_data_d  = DATA_W'(w_cksum_next);
                        out_valid_d = 1'b1;
                        out_last_d  = 1'b1;
                        state_d     = S_CKSUM;
`else
                        state_d     = S_DONE;
`endif
                    end else begin
                        // Natural overflow gives the wrap from the top entry to 0.
                        rom_addr_d  = rom_addr_q + C_ADDR_ONE;
                        dwell_cnt_d = '0;
                        state_d     = S_SETTLE;
                    end
                end
            end

`ifdef ROM_READER_CKSUM_EN
            S_CKSUM: begin
                if (w_accept) begin
                    out_valid_d = 1'b0;
                    state_d     = S_DONE;
                end
            end
`endif

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rom_addr  = rom_addr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_rom_reader.sv
// ============================================================================
// Module   : tb_rom_reader
// Purpose  : Table-driven directed bench for rom_reader; one instance with
//            DWELL=0 and one with DWELL=3, each driving a {addr,~addr} ROM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rom_reader;

`ifdef ROM_READER_CKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] start;
    logic [3:0] first_addr, last_addr;
    logic       out_ready;

    logic [3:0] rom_addr0, rom_addr1;
    logic [7:0] rom_data0, rom_data1;
    logic [7:0] out_data0, out_data1;
    logic       out_valid0, out_valid1, out_last0, out_last1;
    logic       busy0, busy1, done0, done1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign rom_data0 = {rom_addr0, ~rom_addr0};
    assign rom_data1 = {rom_addr1, ~rom_addr1};

    rom_reader #(.ADDR_W(4), .DATA_W(8), .DWELL(0)) u_dut0 (
        .sysclk(clk), .reset(reset), .start(start[0]),
        .first_addr(first_addr), .last_addr(last_addr),
        .rom_addr(rom_addr0), .rom_data(rom_data0),
        .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready),
        .out_last(out_last0), .busy(busy0), .done(done0)
    );

    rom_reader #(.ADDR_W(4), .DATA_W(8), .DWELL(3)) u_dut1 (
        .sysclk(clk), .reset(reset), .start(start[1]),
        .first_addr(first_addr), .last_addr(last_addr),
        .rom_addr(rom_addr1), .rom_data(rom_data1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
        .out_last(out_last1), .busy(busy1), .done(done1)
    );

    typedef struct {
        int         inst;
        logic [3:0] f;
        logic [3:0] l;
        int         stall;
        int         n;
        logic [7:0] last_b;
        logic [7:0] ck;
        int         lat;
        bit         poke;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [7:0] rom_model(input logic [3:0] a);
        return {a, ~a};
    endfunction

    function automatic logic       g_valid(input int i); return i != 0 ? out_valid1 : out_valid0; endfunction
    function automatic logic       g_last (input int i); return i != 0 ? out_last1  : out_last0;  endfunction
    function automatic logic       g_busy (input int i); return i != 0 ? busy1      : busy0;      endfunction
    function automatic logic       g_done (input int i); return i != 0 ? done1      : done0;      endfunction
    function automatic logic [7:0] g_data (input int i); return i != 0 ? out_data1  : out_data0;  endfunction
    function automatic logic [3:0] g_addr (input int i); return i != 0 ? rom_addr1  : rom_addr0;  endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string name, input int i);
        check({name, "_addr"},  {28'd0, g_addr(i)}, 32'd0);
        check({name, "_data"},  {24'd0, g_data(i)}, 32'd0);
        check({name, "_valid"}, {31'd0, g_valid(i)}, 32'd0);
        check({name, "_last"},  {31'd0, g_last(i)}, 32'd0);
        check({name, "_busy"},  {31'd0, g_busy(i)}, 32'd0);
        check({name, "_done"},  {31'd0, g_done(i)}, 32'd0);
    endtask

    task automatic run_pass(input vec_t v);
        int         dw;
        int         c;
        int         nacc;
        int         stall_left;
        int         first_v;
        int         last_acc;
        bit         fin;
        logic [7:0] held;
        logic [7:0] expb;
        logic       expl;
        logic [7:0] last_seen;
        int         stray;

        dw = (v.inst != 0) ? 3 : 0;
        c = 0; nacc = 0; stall_left = v.stall; first_v = -1; last_acc = -1;
        fin = 1'b0; held = '0; last_seen = '0;

        first_addr = v.f;
        last_addr  = v.l;
        out_ready  = 1'b1;
        start[v.inst] = 1'b1;
        tick();
        start[v.inst] = 1'b0;
        check("busy_after_start", {31'd0, g_busy(v.inst)}, 32'd1);
        check("addr_after_start", {28'd0, g_addr(v.inst)}, {28'd0, v.f});

        while (!fin && c < 400) begin
            if (g_valid(v.inst)) begin
                if (first_v < 0) begin
                    first_v = c;
                    check("valid_latency", c, v.lat);
                end
                if (stall_left > 0) begin
                    if (stall_left < v.stall)
                        check("stall_hold", {24'd0, g_data(v.inst)}, {24'd0, held});
                    held = g_data(v.inst);
                    out_ready = 1'b0;
                    stall_left--;
                end else begin
                    out_ready = 1'b1;
                    if (nacc < v.n) begin
                        expb = rom_model(v.f + 4'(nacc));
                        expl = (CK == 0) && (nacc == v.n - 1);
                        if (last_acc >= 0 && v.stall == 0)
                            check("rate", c - last_acc, 2 + dw);
                    end else begin
                        expb = v.ck;
                        expl = 1'b1;
                    end
                    check("byte", {24'd0, g_data(v.inst)}, {24'd0, expb});
                    check("last_flag", {31'd0, g_last(v.inst)}, {31'd0, expl});
                    last_seen = g_data(v.inst);
                    last_acc = c;
                    nacc++;
                end
            end else begin
                out_ready = 1'b1;
            end

            if (g_done(v.inst)) begin
                check("done_timing", c, last_acc + 1);
                check("byte_count", nacc, v.n + CK);
                fin = 1'b1;
            end

            // Extra starts while busy and during the DONE cycle must be dropped.
            start[v.inst] = v.poke && (c == 2 || g_done(v.inst));
            if (v.poke && c == 2) begin
                first_addr = 4'd0;
                last_addr  = 4'd15;
            end
            tick();
            c++;
        end
        start[v.inst] = 1'b0;

        check("done_seen", {31'd0, fin}, 32'd1);
        check("final_byte", {24'd0, last_seen}, {24'd0, (CK != 0) ? v.ck : v.last_b});
        check("done_one_cycle", {31'd0, g_done(v.inst)}, 32'd0);
        check("busy_after_done", {31'd0, g_busy(v.inst)}, 32'd0);
        check("addr_holds", {28'd0, g_addr(v.inst)}, {28'd0, v.l});

        if (v.poke) begin
            stray = 0;
            for (int k = 0; k < 10; k++) begin
                if (g_busy(v.inst) || g_valid(v.inst)) stray++;
                tick();
            end
            check("no_second_pass", stray, 0);
        end
    endtask

    initial begin
        int stray;
        int w;

        //           inst first last stall n  last_b  cksum  lat poke
        vecs[0] = '{0, 4'd2,  4'd4,  0, 3,  8'h4B, 8'hB4, 1, 1'b0};
        vecs[1] = '{0, 4'd0,  4'd1,  5, 2,  8'h1E, 8'h2D, 1, 1'b0};
        vecs[2] = '{0, 4'd14, 4'd1,  0, 4,  8'h1E, 8'hFE, 1, 1'b0};
        vecs[3] = '{0, 4'd0,  4'd15, 0, 16, 8'hF0, 8'hF8, 1, 1'b0};
        vecs[4] = '{0, 4'd9,  4'd9,  0, 1,  8'h96, 8'h96, 1, 1'b0};
        vecs[5] = '{1, 4'd7,  4'd7,  0, 1,  8'h78, 8'h78, 4, 1'b1};
        vecs[6] = '{1, 4'd5,  4'd6,  2, 2,  8'h69, 8'hC3, 4, 1'b0};
        vecs[7] = '{1, 4'd15, 4'd0,  0, 2,  8'h0F, 8'hFF, 4, 1'b0};

        reset = 1'b1;
        start = 2'b00;
        first_addr = '0;
        last_addr  = '0;
        out_ready  = 1'b0;
        tick();
        tick();
        check_idle_outputs("reset0", 0);
        check_idle_outputs("reset1", 1);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_pass(vecs[i]);
            tick();
        end

        // Reset during PRESENT of a full pass.
        first_addr = 4'd0;
        last_addr  = 4'd15;
        out_ready  = 1'b0;
        start[0]   = 1'b1;
        tick();
        start[0]   = 1'b0;
        w = 0;
        while (!out_valid0 && w < 20) begin
            tick();
            w++;
        end
        check("mid_reset_reached_present", {31'd0, out_valid0}, 32'd1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle_outputs("mid_reset", 0);
        out_ready = 1'b1;
        stray = 0;
        for (int k = 0; k < 8; k++) begin
            if (done0 || out_valid0 || busy0) stray++;
            tick();
        end
        check("no_done_after_abort", stray, 0);

        run_pass(vecs[3]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
